mod_mul_d: RTL and testbench
============================

MOD_MUL_D -- requirements
Module: mod_mul_d

Interface
REQ-001 Parameter: CHECK_RANGE, default 1, enables operand range check against Q.
REQ-002 Port: clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 Port: a_i  in  23  operand A, nominally in [0, Q-1].
REQ-005 Port: b_i  in  23  operand B, nominally in [0, Q-1].
REQ-006 Port: valid_i  in  1  operand pair valid.
REQ-007 Port: ready_o  out  1  block accepts the operand pair this cycle.
REQ-008 Port: result_o  out  23  (A*B) mod Q, in [0, Q-1].
REQ-009 Port: valid_o  out  1  result_o is valid.
REQ-010 Port: ready_i  in  1  downstream accepts the result.
REQ-011 Port: err_o  out  1  travels with result_o; set when either operand was >= Q (CHECK_RANGE=1 only).
REQ-012 Port: busy_o  out  1  at least one pipeline stage holds valid data.

Function
REQ-013 Q = 8380417 (Dilithium modulus); product width 46 bits; result width 23 bits.
REQ-014 3-stage pipeline:
- S1: registers a_i, b_i and the range flags.
- S2: registers the full 46-bit product a*b.
- S3: registers the reduced result from the reduction sub-module.
REQ-015 Transfer in: occurs when valid_i && ready_o; transfer out: occurs when valid_o && ready_i.
REQ-016 Latency: with ready_i held high, a pair accepted in cycle N appears on valid_o/result_o in cycle N+3.
REQ-017 Throughput: one pair per cycle while ready_i is high.
REQ-018 Stall: stall = valid_o && !ready_i.
- While stalled, all stage registers and valid bits hold.
- ready_o = !stall.
REQ-019 Bubble collapse: none; a bubble in a stage advances like data.
REQ-020 Stable output: while valid_o && !ready_i, result_o, err_o and valid_o stay stable.
REQ-021 Out-of-range operands (either operand >= Q):
- still multiplied;
- result_o = (a*b) mod Q, correct for any 46-bit product below 2^46;
- err_o = 1 when CHECK_RANGE=1, else err_o = 0.
REQ-022 Output ordering: results leave in acceptance order; no reordering, no drop, no duplication.
REQ-023 Simultaneous accept-in and accept-out in one cycle is legal; the pipeline advances by one stage.
REQ-024 busy_o = OR of S1/S2/S3 valid bits; busy_o = 0 means the pipeline is empty.
REQ-025 valid_i deasserted without a prior accept: no state change.

Reset
REQ-026 rst_ni low, at any time and asynchronously, clears all stage valid bits; valid_o = 0, err_o = 0, busy_o = 0, result_o = 0.
REQ-027 During reset, ready_o = 1 (no stall).
REQ-028 Reset during operation discards all in-flight pairs.
REQ-029 The first accept after reset release is the first result produced.
REQ-030 Datapath registers other than result_o need no reset value.

Structure
REQ-031 Shared package dilithium_pkg holds:
- Q;
- widths COEFF_W = 23 and PROD_W = 46;
- typedefs coeff_t and prod_t.
REQ-032 Reduction is one sub-module instance: red_D.
- Inputs: the 46-bit S2 product (product_i).
- Outputs: 23-bit result_o.
- It is purely combinational and feeds the S3 register.
REQ-033 No other sub-modules; the multiplier is inferred.

Verification
REQ-034 Scenario: a=838041, b=1, ready_i=1 -> result_o=838041, valid_o high exactly 3 cycles after accept, err_o=0.
REQ-035 Scenario: a=8380416, b=8380416 -> result_o=1; then a=4096, b=2048 -> 8191; then a=0, b=5 -> 0.
REQ-036 Scenario: back-to-back stream of 100 random pairs < Q, ready_i=1 -> one result per cycle, in order, all matching the model.
REQ-037 Scenario: 4 pairs, ready_i low for 5 cycles mid-stream -> ready_o low while stalled, result_o stable, no loss or duplication.
REQ-038 Scenario: a=8380417, b=1 with CHECK_RANGE=1 -> result_o=0, err_o=1; repeated with CHECK_RANGE=0 -> err_o=0.
REQ-039 Scenario: assert rst_ni low with 3 pairs in flight -> valid_o and busy_o drop immediately; after release, no stale results appear.

Source files
------------

// File: rtl/dilithium_pkg.sv
// ---------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and types for the Dilithium modular-arithmetic blocks.
//   Q       : Dilithium prime modulus 8380417 = 2^23 - 2^13 + 1
//   COEFF_W : coefficient width (23 bits)
//   PROD_W  : full product width of two coefficients (46 bits)
//   coeff_t : 23-bit coefficient type
//   prod_t  : 46-bit product type
// ---------------------------------------------------------------------------
package dilithium_pkg;

  localparam int COEFF_W = 23;
  localparam int PROD_W  = 2 * COEFF_W;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [PROD_W-1:0]  prod_t;

  localparam coeff_t Q = 23'd8380417;

  // Because 2^23 = Q + 2^13 - 1, the weight of bit 23 folds back to
  // 2^13 - 1 modulo Q. The reduction sub-module relies on this identity.
  localparam int FOLD_SHIFT = 13;

  // True when a coefficient lies in the canonical range [0, Q-1].
  function automatic logic in_range(input coeff_t x);
    return (x < Q);
  endfunction

endpackage

// File: rtl/red_D.sv
// ---------------------------------------------------------------------------
// red_D
// Purely combinational reduction of a 46-bit product modulo Q.
// Correct for every 46-bit input value, not only products of reduced
// operands, so out-of-range operands still yield (a*b) mod Q.
//   product_i : 46-bit unsigned product
//   result_o  : product_i mod Q, in [0, Q-1]
// ---------------------------------------------------------------------------
module red_D
  import dilithium_pkg::*;
(
  input  logic [PROD_W-1:0]  product_i,
  output logic [COEFF_W-1:0] result_o
);

  // Each fold splits x = hi*2^23 + lo and replaces it with
  // hi*(2^13 - 1) + lo, which is congruent modulo Q and much smaller.
  // Bounds after each fold:
  //   fold 1: < 2^36          (hi is 23 bits)
  //   fold 2: < 75,481,089    (hi is 13 bits)
  //   fold 3: < 8,454,136     (hi is at most 8)  -> below 2Q
  // so one conditional subtraction of Q finishes the reduction.
  logic [22:0] hi1;
  logic [22:0] lo1;
  logic [35:0] fold1;
  logic [12:0] hi2;
  logic [22:0] lo2;
  logic [26:0] fold2;
  logic [3:0]  hi3;
  logic [22:0] lo3;
  logic [23:0] fold3;
  logic [23:0] minus_q;

  // Three folds followed by a final conditional subtract.
  always_comb begin
    hi1     = product_i[45:23];
    lo1     = product_i[22:0];
    fold1   = {hi1, 13'd0} - {13'd0, hi1} + {13'd0, lo1};

    hi2     = fold1[35:23];
    lo2     = fold1[22:0];
    fold2   = {1'b0, hi2, 13'd0} - {14'd0, hi2} + {4'd0, lo2};

    hi3     = fold2[26:23];
    lo3     = fold2[22:0];
    fold3   = {7'd0, hi3, 13'd0} - {20'd0, hi3} + {1'b0, lo3};

    minus_q = fold3 - {1'b0, Q};
    if (fold3 >= {1'b0, Q}) begin
      result_o = minus_q[22:0];
    end else begin
      result_o = fold3[22:0];
    end
  end

endmodule

// File: rtl/mod_mul_d.sv
// ---------------------------------------------------------------------------
// mod_mul_d
// Three-stage pipelined modular multiplier: result = (a*b) mod Q.
//   S1 registers operands and range flag, S2 registers the 46-bit product,
//   S3 registers the reduced result. Valid/ready handshake on both sides;
//   the whole pipeline freezes while the output is valid and not taken.
// Parameters:
//   CHECK_RANGE : 1 -> err_o flags any operand >= Q; 0 -> err_o stays 0
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   a_i, b_i  : operands (23 bits)
//   valid_i   : operand pair valid
//   ready_o   : operand pair accepted this cycle (when valid_i)
//   result_o  : (a*b) mod Q
//   valid_o   : result_o valid
//   ready_i   : downstream takes the result
//   err_o     : operand range error, travels with result_o
//   busy_o    : any stage holds valid data
// ---------------------------------------------------------------------------
module mod_mul_d
  import dilithium_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [COEFF_W-1:0] a_i,
  input  logic [COEFF_W-1:0] b_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [COEFF_W-1:0] result_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               err_o,
  output logic               busy_o
);

  logic         s1_valid;
  logic         s2_valid;
  logic         s3_valid;
  coeff_t       s1_a;
  coeff_t       s1_b;
  logic         s1_err;
  prod_t        s2_prod;
  logic         s2_err;
  coeff_t       s3_res;
  logic         s3_err;
  coeff_t       red_res;
  logic         stall;
  logic         advance;
  logic         range_bad;

  // A single global stall: only the output stage can block, and when it
  // does every stage holds, so bubbles are never squeezed out.
  always_comb begin
    stall     = s3_valid && !ready_i;
    advance   = !stall;
    range_bad = CHECK_RANGE && (!in_range(a_i) || !in_range(b_i));
  end

  assign ready_o  = advance;
  assign valid_o  = s3_valid;
  assign result_o = s3_res;
  assign err_o    = s3_err;
  assign busy_o   = s1_valid | s2_valid | s3_valid;

  // Stage valid bits; these alone decide what is in flight, so clearing
  // them on reset discards every pending pair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= valid_i;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1/S2 datapath carries no reset; its contents only matter when the
  // matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      s1_a    <= a_i;
      s1_b    <= b_i;
      s1_err  <= range_bad;
      s2_prod <= prod_t'(s1_a) * prod_t'(s1_b);
      s2_err  <= s1_err;
    end
  end

  red_D u_red (
    .product_i (s2_prod),
    .result_o  (red_res)
  );

  // Output stage is reset so the visible outputs are clean after reset.
  // The error bit is gated with the S2 valid so a bubble never carries a
  // stale error flag onto err_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_res <= '0;
      s3_err <= 1'b0;
    end else if (advance) begin
      s3_res <= red_res;
      s3_err <= s2_valid && s2_err;
    end
  end

endmodule

// File: tb/tb_mod_mul_d.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_d
// Directed testbench for mod_mul_d. Two instances share all inputs: one
// with the range check enabled and one with it disabled.
// ---------------------------------------------------------------------------
module tb_mod_mul_d;

  localparam longint unsigned QM = 64'd8380417;

  int checks = 0;
  int errors = 0;

  logic        clk;
  logic        rst_ni;
  logic [22:0] a_i;
  logic [22:0] b_i;
  logic        valid_i;
  logic        ready_i;
  logic        ready_o;
  logic [22:0] result_o;
  logic        valid_o;
  logic        err_o;
  logic        busy_o;
  logic        nc_ready_o;
  logic [22:0] nc_result_o;
  logic        nc_valid_o;
  logic        nc_err_o;
  logic        nc_busy_o;

  mod_mul_d #(.CHECK_RANGE(1'b1)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  mod_mul_d #(.CHECK_RANGE(1'b0)) dut_nc (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_i  (valid_i),
    .ready_o  (nc_ready_o),
    .result_o (nc_result_o),
    .valid_o  (nc_valid_o),
    .ready_i  (ready_i),
    .err_o    (nc_err_o),
    .busy_o   (nc_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values while reset is held, and after release.
  task automatic test_reset();
    rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0;
    #2 rst_ni = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy_o); end
      checks++; if (result_o !== 23'd0) begin errors++; $display("[TB] FAIL reset_result: got %0d expected 0", result_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", ready_o); end
      step();
    end
    rst_ni = 1'b1;
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %0b expected 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", busy_o); end
  endtask

  // Single pair: result appears exactly three cycles after acceptance.
  task automatic test_latency();
    ready_i = 1'b1; valid_i = 1'b1; a_i = 23'd838041; b_i = 23'd1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL lat_ready: got %0b expected 1", ready_o); end
    step();
    valid_i = 1'b0; a_i = '0; b_i = '0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (valid_o !== (i == 3)) begin errors++; $display("[TB] FAIL lat_valid cycle %0d: got %0b expected %0b", i, valid_o, (i == 3)); end
      if (i == 1) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy: got %0b expected 1", busy_o); end
      end
      if (i == 3) begin
        checks++; if (result_o !== 23'd838041) begin errors++; $display("[TB] FAIL lat_result: got %0d expected 838041", result_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL lat_err: got %0b expected 0", err_o); end
      end
      step();
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL lat_drain_busy: got %0b expected 0", busy_o); end
  endtask

  // Hand-computed products including the (Q-1)^2 corner.
  task automatic test_directed();
    logic [22:0] da [3];
    logic [22:0] db [3];
    logic [22:0] dr [3];
    da = '{23'd8380416, 23'd4096, 23'd0};
    db = '{23'd8380416, 23'd2048, 23'd5};
    dr = '{23'd1, 23'd8191, 23'd0};
    ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      valid_i = (c < 3);
      a_i = (c < 3) ? da[c] : 23'd0;
      b_i = (c < 3) ? db[c] : 23'd0;
      checks++; if (valid_o !== (c >= 3 && c <= 5)) begin errors++; $display("[TB] FAIL dir_valid cycle %0d: got %0b", c, valid_o); end
      if (c >= 3 && c <= 5) begin
        checks++; if (result_o !== dr[c-3]) begin errors++; $display("[TB] FAIL dir_result %0d: got %0d expected %0d", c - 3, result_o, dr[c-3]); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL dir_err %0d: got %0b expected 0", c - 3, err_o); end
      end
      step();
    end
  endtask

  // Out-of-range operands: still reduced correctly; err_o only when checked.
  task automatic test_range();
    logic [22:0] ra [4];
    logic [22:0] rb [4];
    logic [22:0] rr [4];
    logic        re [4];
    ra = '{23'd8380417, 23'd8388607, 23'd3, 23'd8380416};
    rb = '{23'd1, 23'd8388607, 23'd8380418, 23'd1};
    rr = '{23'd0, 23'd32764, 23'd3, 23'd8380416};
    re = '{1'b1, 1'b1, 1'b1, 1'b0};
    ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      valid_i = (c < 4);
      a_i = (c < 4) ? ra[c] : 23'd0;
      b_i = (c < 4) ? rb[c] : 23'd0;
      checks++; if (nc_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rng_nc_ready: got %0b expected 1", nc_ready_o); end
      if (c >= 3 && c <= 6) begin
        checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rng_valid %0d: got %0b expected 1", c - 3, valid_o); end
        checks++; if (result_o !== rr[c-3]) begin errors++; $display("[TB] FAIL rng_result %0d: got %0d expected %0d", c - 3, result_o, rr[c-3]); end
        checks++; if (err_o !== re[c-3]) begin errors++; $display("[TB] FAIL rng_err %0d: got %0b expected %0b", c - 3, err_o, re[c-3]); end
        checks++; if (nc_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rng_nc_valid %0d: got %0b expected 1", c - 3, nc_valid_o); end
        checks++; if (nc_result_o !== rr[c-3]) begin errors++; $display("[TB] FAIL rng_nc_result %0d: got %0d expected %0d", c - 3, nc_result_o, rr[c-3]); end
        checks++; if (nc_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rng_nc_err %0d: got %0b expected 0", c - 3, nc_err_o); end
      end
      step();
    end
    checks++; if (nc_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rng_nc_busy: got %0b expected 0", nc_busy_o); end
  endtask

  // 100 random in-range pairs, one per cycle, checked in order.
  task automatic test_back_to_back();
    logic [22:0] sa [100];
    logic [22:0] sb [100];
    logic [22:0] sr [100];
    int          seen;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      sa[k] = 23'($urandom_range(8380416, 0));
      sb[k] = 23'($urandom_range(8380416, 0));
      sr[k] = 23'((64'(sa[k]) * 64'(sb[k])) % QM);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 106; c++) begin
      valid_i = (c < 100);
      a_i = (c < 100) ? sa[c] : 23'd0;
      b_i = (c < 100) ? sb[c] : 23'd0;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d: got %0b expected 1", c, ready_o); end
      checks++; if (valid_o !== (c >= 3 && c <= 102)) begin errors++; $display("[TB] FAIL b2b_valid cycle %0d: got %0b", c, valid_o); end
      if (valid_o === 1'b1 && c >= 3 && c <= 102) begin
        seen++;
        checks++; if (result_o !== sr[c-3]) begin errors++; $display("[TB] FAIL b2b_result %0d: got %0d expected %0d", c - 3, result_o, sr[c-3]); end
      end
      step();
    end
    checks++; if (seen != 100) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 100", seen); end
  endtask

  // Four pairs with ready_i low for five cycles while results are pending.
  task automatic test_stall();
    logic [22:0] pa [4];
    logic [22:0] pb [4];
    logic [22:0] pr [4];
    logic [22:0] held;
    int          in_ptr;
    int          out_ptr;
    logic        stalled;
    pa = '{23'd1, 23'd2, 23'd8380416, 23'd4096};
    pb = '{23'd1, 23'd3, 23'd2, 23'd4096};
    pr = '{23'd1, 23'd6, 23'd8380415, 23'd16382};
    in_ptr = 0; out_ptr = 0; held = '0;
    for (int c = 0; c < 16; c++) begin
      stalled = (c >= 3 && c < 8);
      ready_i = !stalled;
      valid_i = (in_ptr < 4);
      a_i = (in_ptr < 4) ? pa[in_ptr] : 23'd0;
      b_i = (in_ptr < 4) ? pb[in_ptr] : 23'd0;
      #1;
      checks++; if (ready_o !== !stalled) begin errors++; $display("[TB] FAIL stall_ready cycle %0d: got %0b expected %0b", c, ready_o, !stalled); end
      if (stalled) begin
        checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_hold cycle %0d: got %0b expected 1", c, valid_o); end
        if (c == 3) held = result_o;
        else begin
          checks++; if (result_o !== held) begin errors++; $display("[TB] FAIL stall_result_stable cycle %0d: got %0d expected %0d", c, result_o, held); end
        end
      end
      if (valid_o === 1'b1) begin
        if (out_ptr >= 4) begin
          checks++; errors++; $display("[TB] FAIL stall_extra_result cycle %0d: got %0d expected none", c, result_o);
        end else begin
          checks++; if (result_o !== pr[out_ptr]) begin errors++; $display("[TB] FAIL stall_result %0d: got %0d expected %0d", out_ptr, result_o, pr[out_ptr]); end
          checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_err %0d: got %0b expected 0", out_ptr, err_o); end
        end
        if (ready_i) out_ptr++;
      end
      if (valid_i && ready_o === 1'b1) in_ptr++;
      step();
    end
    checks++; if (in_ptr != 4) begin errors++; $display("[TB] FAIL stall_accepted: got %0d expected 4", in_ptr); end
    checks++; if (out_ptr != 4) begin errors++; $display("[TB] FAIL stall_delivered: got %0d expected 4", out_ptr); end
    valid_i = 1'b0;
    ready_i = 1'b1;
  endtask

  // Reset with three pairs in flight; nothing stale may emerge afterwards.
  task automatic test_reset_flight();
    logic [22:0] fa [3];
    logic [22:0] fb [3];
    fa = '{23'd8380417, 23'd10, 23'd20};
    fb = '{23'd1, 23'd10, 23'd20};
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      valid_i = 1'b1; a_i = fa[c]; b_i = fb[c];
      step();
    end
    valid_i = 1'b0; a_i = '0; b_i = '0;
    ready_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_pre_valid: got %0b expected 1", valid_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_pre_err: got %0b expected 1", err_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_pre_busy: got %0b expected 1", busy_o); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_valid: got %0b expected 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_busy: got %0b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_err: got %0b expected 0", err_o); end
    checks++; if (result_o !== 23'd0) begin errors++; $display("[TB] FAIL rf_result: got %0d expected 0", result_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_ready: got %0b expected 1", ready_o); end
    step();
    rst_ni = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_stale_valid cycle %0d: got %0b expected 0", c, valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_stale_busy cycle %0d: got %0b expected 0", c, busy_o); end
    end
    valid_i = 1'b1; a_i = 23'd5; b_i = 23'd7;
    step();
    valid_i = 1'b0; a_i = '0; b_i = '0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (valid_o !== (i == 3)) begin errors++; $display("[TB] FAIL rf_first_valid cycle %0d: got %0b expected %0b", i, valid_o, (i == 3)); end
      if (i == 3) begin
        checks++; if (result_o !== 23'd35) begin errors++; $display("[TB] FAIL rf_first_result: got %0d expected 35", result_o); end
      end
      if (i < 3) step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_range();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
